// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV32/RV64 immediate decoder feeding a valid/ready output FIFO, with illegal-opcode counting.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       fmt,
    output logic             illegal,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [2:0] F_NONE  = 3'd0;
    localparam logic [2:0] F_I     = 3'd1;
    localparam logic [2:0] F_S     = 3'd2;
    localparam logic [2:0] F_B     = 3'd3;
    localparam logic [2:0] F_U     = 3'd4;
    localparam logic [2:0] F_J     = 3'd5;
    localparam logic [2:0] F_SHAMT = 3'd6;

    logic [31:0]      imm32;
    logic [XLEN-1:0]  dec_imm;
    logic [2:0]       dec_fmt;
    logic             dec_ill;
    logic             push;
    logic             pop;
    logic [XLEN-1:0]  imm_q [DEPTH];
    logic [XLEN-1:0]  imm_d [DEPTH];
    logic [2:0]       fmt_q [DEPTH];
    logic [2:0]       fmt_d [DEPTH];
    logic             ill_q [DEPTH];
    logic             ill_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        imm32   = 32'd0;
        dec_fmt = F_NONE;
        dec_ill = 1'b0;
        case (instr[6:0])
            7'b0110111, 7'b0010111: begin
                imm32   = {instr[31:12], 12'b0};
                dec_fmt = F_U;
            end
            7'b1101111: begin
                imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                dec_fmt = F_J;
            end
            7'b1100111, 7'b0000011, 7'b1110011: begin
                imm32   = {{20{instr[31]}}, instr[31:20]};
                dec_fmt = F_I;
            end
            7'b0010011: begin
                // Shift-immediates carry a 5-bit (RV32) or 6-bit (RV64) unsigned amount
                if (instr[14:12] == 3'b001 || instr[14:12] == 3'b101) begin
                    imm32   = {26'd0, (XLEN == 64) ? instr[25] : 1'b0, instr[24:20]};
                    dec_fmt = F_SHAMT;
                end else begin
                    imm32   = {{20{instr[31]}}, instr[31:20]};
                    dec_fmt = F_I;
                end
            end
            7'b0100011: begin
                imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                dec_fmt = F_S;
            end
            7'b1100011: begin
                imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                dec_fmt = F_B;
            end
            7'b0110011: dec_ill = 1'b0;
            default:    dec_ill = 1'b1;
        endcase
        dec_imm = XLEN'($signed(imm32));
    end

    assign in_ready  = cnt_q != CW'(DEPTH);
    assign out_valid = cnt_q != '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        imm_d     = imm_q;
        fmt_d     = fmt_q;
        ill_d     = ill_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        // Counted even when the push itself is dropped by a flush
        err_cnt_d = (push && dec_ill && err_cnt_q != '1) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                imm_d[wr_ptr_q] = dec_imm;
                fmt_d[wr_ptr_q] = dec_fmt;
                ill_d[wr_ptr_q] = dec_ill;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm_q     <= '{default: '0};
            fmt_q     <= '{default: '0};
            ill_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            imm_q     <= imm_d;
            fmt_q     <= fmt_d;
            ill_q     <= ill_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign imm     = imm_q[rd_ptr_q];
    assign fmt     = fmt_q[rd_ptr_q];
    assign illegal = ill_q[rd_ptr_q];
    assign err_cnt = err_cnt_q;
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the RV32/RV64 decode stage. It takes a full 32-bit instruction word instead of pre-split immediate fields. It detects the instruction format from the opcode and produces a sign- or zero-extended XLEN-wide immediate. Results pass through a valid/ready output FIFO, so decode can stall independently of fetch. It also flags illegal opcodes and keeps a saturating error count.

Parameters:
XLEN, 32, immediate/output width; legal values 32 or 64.
DEPTH, 2, output FIFO entries; power of two, minimum 2.
CNT_W, 16, width of the illegal-opcode counter.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous FIFO clear (branch mispredict).
in_valid  input  1  instruction word valid.
in_ready  output  1  block can accept instruction this cycle.
instr  input  32  raw instruction word.
out_valid  output  1  head FIFO entry valid.
out_ready  input  1  consumer accepts head entry.
imm  output  XLEN  decoded immediate of head entry.
fmt  output  3  format of head entry: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT.
illegal  output  1  head entry opcode unrecognised.
err_cnt  output  CNT_W  count of accepted illegal instructions, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous): FIFO empty, out_valid=0, imm=0, fmt=0, illegal=0, err_cnt=0. Reset asserted mid-transfer discards all entries.
- Accept: push occurs when in_valid && in_ready. in_ready = !full, taken from the registered count; it does not depend combinationally on out_ready.
- Pop: occurs when out_valid && out_ready. Simultaneous push and pop when not full keeps the count unchanged.
- Latency: an instruction accepted in cycle N appears at the head with out_valid=1 in cycle N+1 if the FIFO was empty. Otherwise it follows strict FIFO order.
- imm/fmt/illegal are registered FIFO outputs. They hold stable while out_valid && !out_ready, and are don't-care when out_valid=0.
- Decode is combinational on instr at push time. Opcode instr[6:0]:
  - 0110111 LUI, 0010111 AUIPC -> U: {instr[31:12],12'b0}, sign-extended to XLEN.
  - 1101111 JAL -> J: {instr[31],instr[19:12],instr[20],instr[30:21],0}, sign-extended.
  - 1100111 JALR, 0000011 LOAD, 1110011 SYSTEM -> I: instr[31:20], sign-extended.
  - 0010011 OP-IMM:
    - funct3 001 or 101 -> SHAMT: zero-extended instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
    - other funct3 -> I.
  - 0100011 STORE -> S: {instr[31:25],instr[11:7]}, sign-extended.
  - 1100011 BRANCH -> B: {instr[31],instr[7],instr[30:25],instr[11:8],0}, sign-extended.
  - 0110011 OP (R-type) -> NONE, imm=0, illegal=0.
  - Any other opcode -> NONE, imm=0, illegal=1.
- err_cnt increments by 1 on each accepted illegal instruction. It saturates at all-ones and does not wrap. flush does not clear it.
- flush=1: next cycle the FIFO is empty and out_valid=0. A push in the same cycle as flush is dropped, and the dropped push still updates err_cnt. A pop in the same cycle as flush is ignored. in_ready follows the count rule, so it is 1 the cycle after flush.
- Full FIFO with out_ready=1: in_ready stays 0 that cycle. The freed slot is usable from the next cycle.
- Pointer wrap-around: read and write pointers wrap modulo DEPTH. Full/empty is resolved by an explicit occupancy counter of width log2(DEPTH)+1.

Test Plan:
- Reset, then push 0x12345037 (LUI), out_ready=1 -> next cycle out_valid=1, imm=0x12345000, fmt=4, illegal=0.
- Push 0xFE000EE3 (BEQ -4), then 0xFF9FF0EF (JAL -8) back-to-back -> heads in order: imm=0xFFFFFFFC fmt=3, then imm=0xFFFFFFF8 fmt=5. With XLEN=64 the upper 32 bits are all ones.
- Push 0x4030D093 (SRAI x1,x1,3) -> imm=3, fmt=6. Push 0xFFF00093 (ADDI -1) -> imm=0xFFFFFFFF, fmt=1.
- DEPTH=2, out_ready=0, drive in_valid with three words -> in_ready=0 after two accepts, third held. Raise out_ready -> all three emerge in order; head values stable while stalled.
- Push 0x0000007F twice -> illegal=1, fmt=0, imm=0, err_cnt=2. With CNT_W=2, push five illegal words -> err_cnt stays 3.
- Fill the FIFO, assert flush together with a new push -> next cycle out_valid=0, in_ready=1, dropped word never appears. Assert rst_n=0 mid-stream -> all outputs return to reset values immediately.
